xadc_drp_sequencer: RTL
=======================

Name: xadc_drp_sequencer

Overview:
Sequences the XADC dynamic reconfiguration port (DRP). It round-robin reads the four auxiliary channels that carry the joystick and analog inputs: VAUX6, VAUX7, VAUX14 and VAUX15. Each conversion is stored as a 12-bit result. The block also publishes 4-bit joystick coordinates (vrx/vry) for game logic and a sweep-done strobe for the display/LED path. It sits between xadc_wiz_0 and every consumer of analog data, so no consumer drives daddr/den directly.

Parameters:
SAMPLE_DIV, 100000, clock cycles between sweep start ticks (1 kHz at 100 MHz); minimum 16
TIMEOUT, 63, maximum cycles to wait for drdy after den before abandoning the read
NUM_CH, 4, number of channels per sweep; fixed at 4 in this revision

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
enable  in  1  when high, sweeps start on each sample tick
daddr_out  out  7  DRP address to xadc_wiz_0
den_out  out  1  DRP enable, single-cycle pulse
dwe_out  out  1  DRP write enable, tied 0 (read-only block)
di_out  out  16  DRP write data, tied 0
do_in  in  16  DRP read data
drdy_in  in  1  DRP data ready
result_flat  out  48  four 12-bit results, ch0 in [11:0] … ch3 in [47:36]
vrx  out  4  joystick X = result ch1[11:8]
vry  out  4  joystick Y = result ch0[11:8]
sweep_done  out  1  one-cycle pulse after all four channels are processed
busy  out  1  high while a sweep is in progress
timeout_err  out  1  sticky flag, set on any drdy timeout, cleared only by reset

Behaviour:
- Reset values: all outputs 0; daddr_out = 7'h16; FSM = IDLE; idx = 0; tick counter = 0.
- Tick counter: free-running 0..SAMPLE_DIV-1. It pulses tick for one cycle at SAMPLE_DIV-1, then wraps to 0. It runs regardless of enable.
- Channel address map (idx → daddr): 0→7'h16, 1→7'h17, 2→7'h1E, 3→7'h1F.
- FSM states: IDLE, ISSUE, WAIT, NEXT, DONE.
  - IDLE: on tick && enable, set idx = 0 and go to ISSUE. drdy_in is ignored in this state.
  - ISSUE: daddr_out = addr[idx], den_out = 1 for exactly this cycle, clear the wait counter, go to WAIT.
  - WAIT: if drdy_in, capture do_in[15:4] into result[idx] and go to NEXT. If the wait counter reaches TIMEOUT, set timeout_err, leave result[idx] unchanged and go to NEXT. If drdy_in and timeout coincide, drdy wins: the data is captured and no error is flagged.
  - NEXT: if idx == 3, go to DONE; otherwise idx++ and go to ISSUE.
  - DONE: sweep_done = 1 for one cycle; vrx/vry load from the updated ch1/ch0 results in this same cycle; go to IDLE.
- busy is high in every state except IDLE.
- Latency: a sweep with immediate drdy takes 4 × 3 + 1 = 13 cycles from leaving IDLE to the sweep_done pulse. result_flat updates one channel at a time during the sweep. vrx/vry update atomically, only at DONE.
- Ticks that arrive while busy are dropped; there is no queueing.
- Dropping enable mid-sweep lets the current sweep complete; no new sweep starts.
- daddr_out holds its last value outside ISSUE. den_out is never high for two consecutive cycles.
- Reset asserted mid-sweep returns everything to reset values immediately. A drdy that arrives after reset is released lands in IDLE and is ignored.
- The 12-bit result is unsigned; no scaling is done in this block. Decimal conversion stays with the consumers.

Decomposition:
- Shared package xadc_pkg: the channel address constants (ADDR_VAUX6=7'h16, ADDR_VAUX7=7'h17, ADDR_VAUX14=7'h1E, ADDR_VAUX15=7'h1F), the FSM state encodings, and the RESULT_W=12 constant.
- One sub-module: sample_tick_gen. It holds the SAMPLE_DIV counter, is parameterised by the divisor, and has a tick output. It is reusable for the display refresh.

Test Plan:
- Reset: assert reset mid-WAIT, with a stimulus drdy pending → all outputs 0, daddr_out = 7'h16, busy = 0; the drdy one cycle after release is ignored.
- Nominal sweep: SAMPLE_DIV = 16, enable = 1, DRP model returns drdy 2 cycles after den with do_in = {addr-dependent 12'hA50 + idx, 4'h0} → den pulses at addresses 16, 17, 1E, 1F in that order; results 0xA50–0xA53; vry = 4'hA, vrx = 4'hA; sweep_done is a single-cycle pulse.
- Joystick quantisation: ch0 = 12'h3FF, ch1 = 12'hF00 → vry = 4'h3, vrx = 4'hF, both changing only in the sweep_done cycle.
- Timeout: model withholds drdy for channel 2 (7'h1E) → timeout_err rises exactly TIMEOUT cycles after that den; ch2 keeps its previous value; the sweep still completes and sweep_done pulses.
- Drdy/timeout coincidence: drdy on the TIMEOUT-th wait cycle → data captured, timeout_err stays 0.
- Enable and ticks: drop enable during the idx = 1 read → the sweep finishes with sweep_done; the next tick starts no sweep. Force a tick while busy → no extra den and no restart.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared constants for the XADC DRP sequencer.
//   RESULT_W      : width of one conversion result
//   ADDR_VAUX*    : DRP status-register addresses of the sampled aux channels
//   state_t       : sequencer FSM encoding
//   ch_addr()     : channel index -> DRP address
package xadc_pkg;

  localparam int unsigned RESULT_W = 12;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned JOY_W    = 4;

  localparam logic [ADDR_W-1:0] ADDR_VAUX6  = 7'h16;
  localparam logic [ADDR_W-1:0] ADDR_VAUX7  = 7'h17;
  localparam logic [ADDR_W-1:0] ADDR_VAUX14 = 7'h1E;
  localparam logic [ADDR_W-1:0] ADDR_VAUX15 = 7'h1F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Round-robin channel order: VAUX6, VAUX7, VAUX14, VAUX15.
  function automatic logic [ADDR_W-1:0] ch_addr(input logic [IDX_W-1:0] idx);
    logic [ADDR_W-1:0] a;
    case (idx)
      2'd0:    a = ADDR_VAUX6;
      2'd1:    a = ADDR_VAUX7;
      2'd2:    a = ADDR_VAUX14;
      default: a = ADDR_VAUX15;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/xadc_drp_sequencer_sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   tick : registered pulse, high while the counter sits at DIV-1
module sample_tick_gen #(
  parameter int unsigned DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt;

  // Tick is registered one count early so it lines up with cnt == DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_W'(DIV - 2));
      if (cnt == CNT_W'(DIV - 1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// XADC DRP read sequencer: on each sample tick (when enabled) reads VAUX6,
// VAUX7, VAUX14, VAUX15 in turn and publishes 12-bit results, joystick
// nibbles and a sweep-done strobe.
//   CLK100MHZ, reset        : clock, asynchronous active-high reset
//   enable                  : allow new sweeps to start on ticks
//   daddr_out/den_out/...   : DRP request to xadc_wiz_0 (read-only)
//   do_in/drdy_in           : DRP response
//   result_flat             : ch0 in [11:0] .. ch3 in [47:36]
//   vrx/vry                 : ch1/ch0 top nibbles, updated only at sweep end
//   sweep_done/busy         : sweep status
//   timeout_err             : sticky drdy-timeout flag
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned TIMEOUT    = 63,
  parameter int unsigned NUM_CH     = 4
) (
  input  logic                         CLK100MHZ,
  input  logic                         reset,
  input  logic                         enable,
  output logic [ADDR_W-1:0]            daddr_out,
  output logic                         den_out,
  output logic                         dwe_out,
  output logic [DATA_W-1:0]            di_out,
  input  logic [DATA_W-1:0]            do_in,
  input  logic                         drdy_in,
  output logic [NUM_CH*RESULT_W-1:0]   result_flat,
  output logic [JOY_W-1:0]             vrx,
  output logic [JOY_W-1:0]             vry,
  output logic                         sweep_done,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  state_t                            state, state_nxt;
  logic [IDX_W-1:0]                  idx, idx_nxt;
  logic [WCNT_W-1:0]                 wcnt, wcnt_nxt;
  logic [NUM_CH-1:0][RESULT_W-1:0]   res, res_nxt;
  logic [ADDR_W-1:0]                 daddr_nxt;
  logic                              den_nxt;
  logic [JOY_W-1:0]                  vrx_nxt, vry_nxt;
  logic                              done_nxt;
  logic                              busy_nxt;
  logic                              terr_nxt;
  logic                              tick;
  logic                              unused_do_lsb;

  // Sample tick source.
  sample_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .clk  (CLK100MHZ),
    .rst  (reset),
    .tick (tick)
  );

  // Read-only DRP master; low conversion bits are below the 12-bit result.
  assign dwe_out       = 1'b0;
  assign di_out        = '0;
  assign result_flat   = res;
  assign unused_do_lsb = ^do_in[3:0];

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wcnt_nxt  = wcnt;
    res_nxt   = res;
    daddr_nxt = daddr_out;
    den_nxt   = 1'b0;
    vrx_nxt   = vrx;
    vry_nxt   = vry;
    done_nxt  = 1'b0;
    terr_nxt  = timeout_err;

    case (state)
      ST_IDLE: begin
        if (tick && enable) begin
          idx_nxt   = '0;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // wcnt counts WAIT cycles since den, starting at 1.
        wcnt_nxt  = WCNT_W'(1);
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // drdy takes priority over a coincident timeout.
        if (drdy_in) begin
          res_nxt[idx] = do_in[DATA_W-1 -: RESULT_W];
          state_nxt    = ST_NEXT;
        end else if (wcnt == WCNT_W'(TIMEOUT)) begin
          terr_nxt  = 1'b1;
          state_nxt = ST_NEXT;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      ST_NEXT: begin
        if (idx == IDX_W'(NUM_CH - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are keyed on the state being entered.
    if (state_nxt == ST_ISSUE) begin
      den_nxt   = 1'b1;
      daddr_nxt = ch_addr(idx_nxt);
    end
    if (state_nxt == ST_DONE) begin
      done_nxt = 1'b1;
      vrx_nxt  = res_nxt[1][RESULT_W-1 -: JOY_W];
      vry_nxt  = res_nxt[0][RESULT_W-1 -: JOY_W];
    end
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      wcnt        <= '0;
      res         <= '0;
      daddr_out   <= ADDR_VAUX6;
      den_out     <= 1'b0;
      vrx         <= '0;
      vry         <= '0;
      sweep_done  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      wcnt        <= wcnt_nxt;
      res         <= res_nxt;
      daddr_out   <= daddr_nxt;
      den_out     <= den_nxt;
      vrx         <= vrx_nxt;
      vry         <= vry_nxt;
      sweep_done  <= done_nxt;
      busy        <= busy_nxt;
      timeout_err <= terr_nxt;
    end
  end

endmodule
